// File: rtl/bcd_step_counter_pkg.sv
// Shared constants for the two-digit BCD step counter: digit width,
// seven-segment patterns (active-low, bit 0 = segment a) and digit saturation.
package bcd_step_counter_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Clamp a loaded digit into the BCD range so count never holds A-F.
   function automatic logic [DIGIT_W-1:0] sat9(input logic [DIGIT_W-1:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/bcd_step_counter_seg7_dec.sv
// Combinational BCD digit to seven-segment decode; non-BCD inputs show blank.
module seg7_dec
   import bcd_step_counter_pkg::*;
#(
   parameter int ACTIVE_LOW_SEG = 1
) (
   input  logic [DIGIT_W-1:0] digit,
   output logic [6:0]         seg
);

   logic [6:0] pat;

   always_comb begin
      pat = SEG_BLANK;
      case (digit)
         4'd0: pat = SEG_0;
         4'd1: pat = SEG_1;
         4'd2: pat = SEG_2;
         4'd3: pat = SEG_3;
         4'd4: pat = SEG_4;
         4'd5: pat = SEG_5;
         4'd6: pat = SEG_6;
         4'd7: pat = SEG_7;
         4'd8: pat = SEG_8;
         4'd9: pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      seg = (ACTIVE_LOW_SEG != 0) ? pat : ~pat;
   end

endmodule

// File: rtl/bcd_step_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of the divided clock,
// with registered seven-segment outputs for both digits.
module bcd_step_counter
   import bcd_step_counter_pkg::*;
#(
   parameter int ACTIVE_LOW_SEG = 1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       clk_1,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] count,
   output logic       wrap,
   output logic [6:0] hex0,
   output logic [6:0] hex1
);

   localparam logic [6:0] SEG_RESET = (ACTIVE_LOW_SEG != 0) ? SEG_0 : ~SEG_0;

   logic               clk_1_d;
   logic               step;
   logic [DIGIT_W-1:0] ones, tens, ones_n, tens_n;
   logic               wrap_n;
   logic [6:0]         dec0, dec1;

   assign step = clk_1 & ~clk_1_d;
   assign ones = count[3:0];
   assign tens = count[7:4];

   always_comb begin
      ones_n = ones;
      tens_n = tens;
      wrap_n = 1'b0;
      if (up) begin
         if (ones == 4'd9) begin
            ones_n = '0;
            if (tens == 4'd9) begin
               tens_n = '0;
               wrap_n = 1'b1;
            end else begin
               tens_n = tens + 4'd1;
            end
         end else begin
            ones_n = ones + 4'd1;
         end
      end else begin
         if (ones == 4'd0) begin
            ones_n = 4'd9;
            if (tens == 4'd0) begin
               tens_n = 4'd9;
               wrap_n = 1'b1;
            end else begin
               tens_n = tens - 4'd1;
            end
         end else begin
            ones_n = ones - 4'd1;
         end
      end
   end

   seg7_dec #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_dec0 (.digit(ones), .seg(dec0));
   seg7_dec #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_dec1 (.digit(tens), .seg(dec1));

   // clk_1_d resets high so a clk_1 already high at release is not an edge.
   always_ff @(posedge clk) begin
      if (clr) begin
         clk_1_d <= 1'b1;
         count   <= '0;
         wrap    <= 1'b0;
         hex0    <= SEG_RESET;
         hex1    <= SEG_RESET;
      end else begin
         clk_1_d <= clk_1;
         hex0    <= dec0;
         hex1    <= dec1;
         wrap    <= 1'b0;
         if (load) begin
            count <= {sat9(load_val[7:4]), sat9(load_val[3:0])};
         end else if (step && en) begin
            count <= {tens_n, ones_n};
            wrap  <= wrap_n;
         end
      end
   end

endmodule

// File: tb/tb_bcd_step_counter.sv
// Randomised and directed bench for bcd_step_counter against an integer 0..99 model.
module tb_bcd_step_counter;

   logic       clk = 1'b0;
   logic       clr, clk_1, en, up, load;
   logic [7:0] load_val;
   logic [7:0] count;
   logic       wrap;
   logic [6:0] hex0, hex1;

   int checks = 0;
   int failures = 0;

   bcd_step_counter #(.ACTIVE_LOW_SEG(1)) dut (
      .clk(clk), .clr(clr), .clk_1(clk_1), .en(en), .up(up), .load(load),
      .load_val(load_val), .count(count), .wrap(wrap), .hex0(hex0), .hex1(hex1)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Model: count as a plain integer 0..99, hex lags count by one cycle.
   int m_val = 0;
   int m_hex_val = 0;
   bit m_wrap = 0;
   bit m_prev = 1;
   bit m_valid = 0;

   function automatic int sat(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (clr) begin
         m_val = 0; m_hex_val = 0; m_wrap = 0; m_prev = 1; m_valid = 1;
      end else begin
         bit step;
         step = clk_1 && !m_prev;
         m_hex_val = m_val;
         m_wrap = 0;
         if (load) begin
            m_val = sat(int'(load_val[7:4])) * 10 + sat(int'(load_val[3:0]));
         end else if (step && en) begin
            if (up) begin
               m_wrap = (m_val == 99);
               m_val = (m_val + 1) % 100;
            end else begin
               m_wrap = (m_val == 0);
               m_val = (m_val + 99) % 100;
            end
         end
         m_prev = clk_1;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("count", int'(count), int'(to_bcd(m_val)));
         chk("wrap", int'(wrap), int'(m_wrap));
         chk("hex0", int'(hex0), int'(seg_tab[m_hex_val % 10]));
         chk("hex1", int'(hex1), int'(seg_tab[m_hex_val / 10]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rise();
      clk_1 = 1'b0; tick();
      clk_1 = 1'b1; tick();
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; load_val = v; tick();
      load = 1'b0;
   endtask

   initial begin
      clr = 1'b1; clk_1 = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
      repeat (3) tick();
      clr = 1'b0;
      chk("rst_count", int'(count), 'h00);
      chk("rst_hex0", int'(hex0), 'b1000000);
      chk("rst_hex1", int'(hex1), 'b1000000);
      repeat (3) tick();
      chk("no_step_high_release", int'(count), 'h00);
      rise();
      chk("first_true_edge", int'(count), 'h01);

      do_load(8'h98);
      chk("load98", int'(count), 'h98);
      rise();
      chk("up_99", int'(count), 'h99);
      chk("up_99_wrap", int'(wrap), 0);
      rise();
      chk("up_wrap_00", int'(count), 'h00);
      chk("up_wrap_pulse", int'(wrap), 1);
      tick();
      chk("wrap_one_cycle", int'(wrap), 0);
      chk("hex0_00", int'(hex0), 'b1000000);
      chk("hex1_00", int'(hex1), 'b1000000);

      up = 1'b0;
      do_load(8'h10);
      rise();
      chk("down_09", int'(count), 'h09);
      do_load(8'h00);
      rise();
      chk("down_wrap_99", int'(count), 'h99);
      chk("down_wrap_pulse", int'(wrap), 1);

      do_load(8'h00);
      clk_1 = 1'b0; tick();
      clk_1 = 1'b1; load = 1'b1; load_val = 8'hAF; tick();
      load = 1'b0;
      chk("load_sat_AF", int'(count), 'h99);
      chk("load_no_wrap", int'(wrap), 0);

      en = 1'b0;
      repeat (5) rise();
      chk("hold_en0", int'(count), 'h99);

      en = 1'b1; up = 1'b1;
      do_load(8'h47);
      rise();
      chk("mid_48", int'(count), 'h48);
      clr = 1'b1; tick();
      clr = 1'b0;
      chk("clr_mid_count", int'(count), 'h00);
      chk("clr_mid_wrap", int'(wrap), 0);
      chk("clr_mid_hex0", int'(hex0), 'b1000000);

      for (int i = 0; i < 3000; i++) begin
         clr      = ($urandom_range(63) == 0);
         load     = ($urandom_range(15) == 0);
         load_val = 8'($urandom);
         en       = ($urandom_range(3) != 0);
         if ($urandom_range(7) == 0) up = ~up;
         if ($urandom_range(2) == 0) clk_1 = ~clk_1;
         tick();
      end
      clr = 1'b0; load = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
